// File: rtl/adc_trigger_capture.sv
// Triggered ADC capture: decimated samples go into a circular buffer with pre-trigger history,
// and each frame of DEPTH samples is sent out as one AXI4-Stream packet.
module adc_trigger_capture #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned AUTO_TIMEOUT = 100000
) (
  input  logic                     axis_aclk,
  input  logic                     axis_aresetn,
  input  logic                     adc_valid,
  input  logic [DATA_W-1:0]        adc_data,
  input  logic [1:0]               cfg_mode,
  input  logic [DATA_W-1:0]        cfg_level,
  input  logic                     cfg_edge,
  input  logic [$clog2(DEPTH)-1:0] cfg_pretrig,
  input  logic [7:0]               cfg_decim,
  input  logic                     arm,
  output logic                     axis_tvalid,
  input  logic                     axis_tready,
  output logic [DATA_W-1:0]        axis_tdata,
  output logic                     axis_tlast,
  output logic                     status_busy,
  output logic                     status_triggered
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [1:0] MODE_AUTO   = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_READ} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] level_q, level_d;
  logic              edge_q, edge_d;
  logic [AW-1:0]     pretrig_q, pretrig_d;
  logic [7:0]        decim_q, decim_d, dec_cnt_q, dec_cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, cnt_q, cnt_d, trig_addr_q, trig_addr_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              force_q, force_d, trig_q, trig_d, busy_q, busy_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       rd_cnt_q, rd_cnt_d;
  logic              pend_q, pend_d, pend_last_q, pend_last_d;
  logic              tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              pf_vld_q, pf_vld_d, pf_last_q, pf_last_d;
  logic [DATA_W-1:0] pf_data_q, pf_data_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic          capture_c, accept_c, write_c, hit_c, pop_c, issue_c, enter_pre_c;
  logic [1:0]    occ_c;
  logic [AW-1:0] post_len_c;

  always_comb begin
    state_d = state_q;       mode_d = mode_q;         level_d = level_q;
    edge_d = edge_q;         pretrig_d = pretrig_q;   decim_d = decim_q;
    dec_cnt_d = dec_cnt_q;   wr_ptr_d = wr_ptr_q;     cnt_d = cnt_q;
    trig_addr_d = trig_addr_q; prev_d = prev_q;       prev_vld_d = prev_vld_q;
    to_cnt_d = to_cnt_q;     force_d = force_q;       trig_d = trig_q;
    rd_ptr_d = rd_ptr_q;     rd_cnt_d = rd_cnt_q;
    tvalid_d = tvalid_q;     tdata_d = tdata_q;       tlast_d = tlast_q;
    pf_vld_d = pf_vld_q;     pf_data_d = pf_data_q;   pf_last_d = pf_last_q;
    write_c = 1'b0;
    enter_pre_c = 1'b0;

    pop_c      = tvalid_q && axis_tready;
    post_len_c = AW'(DEPTH - 1) - pretrig_q;
    capture_c  = (state_q == S_PRE && pretrig_q != '0) || state_q == S_WAIT || state_q == S_POST;
    accept_c   = capture_c && adc_valid && (dec_cnt_q == '0);
    hit_c      = prev_vld_q && (edge_q ? (prev_q > level_q && adc_data <= level_q)
                                       : (prev_q < level_q && adc_data >= level_q));

    // Decimation and buffer write
    if (capture_c && adc_valid) dec_cnt_d = (dec_cnt_q == decim_q) ? 8'd0 : dec_cnt_q + 8'd1;
    if (accept_c) begin
      write_c    = 1'b1;
      wr_ptr_d   = wr_ptr_q + AW'(1);
      prev_d     = adc_data;
      prev_vld_d = 1'b1;
    end

    case (state_q)
      S_IDLE: if (arm) enter_pre_c = 1'b1;
      S_PRE: begin
        if (pretrig_q == '0) begin
          state_d = S_WAIT;
        end else if (accept_c) begin
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == pretrig_q - AW'(1)) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mode_q == MODE_AUTO) begin
          if (to_cnt_q == TW'(AUTO_TIMEOUT - 1)) force_d = 1'b1;
          else to_cnt_d = to_cnt_q + TW'(1);
        end
        if (accept_c && (hit_c || force_q)) begin
          trig_addr_d = wr_ptr_q;
          trig_d      = 1'b1;
          cnt_d       = '0;
          state_d     = S_POST;
        end
      end
      S_POST: begin
        if (post_len_c == '0 || (accept_c && cnt_q == post_len_c - AW'(1))) begin
          state_d  = S_READ;
          rd_ptr_d = trig_addr_q - pretrig_q;
          rd_cnt_d = '0;
        end else if (accept_c) begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_READ: begin
        if (pop_c && tlast_q) begin
          if (mode_q == MODE_AUTO || mode_q == MODE_NORMAL) enter_pre_c = 1'b1;
          else state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every (re)arm restarts the capture with a fresh configuration snapshot
    if (enter_pre_c) begin
      state_d    = S_PRE;
      mode_d     = cfg_mode;
      level_d    = cfg_level;
      edge_d     = cfg_edge;
      pretrig_d  = cfg_pretrig;
      decim_d    = cfg_decim;
      dec_cnt_d  = '0;
      cnt_d      = '0;
      prev_vld_d = 1'b0;
      to_cnt_d   = '0;
      force_d    = 1'b0;
      trig_d     = 1'b0;
    end
    busy_d = (state_d != S_IDLE);

    // Readout: at most two beats in flight (output reg + prefetch, or one pending RAM read)
    occ_c   = 2'(tvalid_q && !pop_c) + 2'(pf_vld_q) + 2'(pend_q);
    issue_c = (state_q == S_READ) && (rd_cnt_q != (AW+1)'(DEPTH)) && (occ_c < 2'd2);
    if (issue_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      rd_cnt_d = rd_cnt_q + (AW+1)'(1);
    end
    pend_d      = issue_c;
    pend_last_d = (rd_cnt_q == (AW+1)'(DEPTH - 1));

    if (!tvalid_q || pop_c) begin
      if (pf_vld_q) begin
        tvalid_d  = 1'b1;
        tdata_d   = pf_data_q;
        tlast_d   = pf_last_q;
        pf_vld_d  = pend_q;
        pf_data_d = rd_data_q;
        pf_last_d = pend_last_q;
      end else begin
        tvalid_d = pend_q;
        tdata_d  = rd_data_q;
        tlast_d  = pend_q && pend_last_q;
      end
    end else if (pend_q) begin
      pf_vld_d  = 1'b1;
      pf_data_d = rd_data_q;
      pf_last_d = pend_last_q;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q <= S_IDLE;     mode_q <= '0;        level_q <= '0;
      edge_q <= 1'b0;        pretrig_q <= '0;     decim_q <= '0;
      dec_cnt_q <= '0;       wr_ptr_q <= '0;      cnt_q <= '0;
      trig_addr_q <= '0;     prev_q <= '0;        prev_vld_q <= 1'b0;
      to_cnt_q <= '0;        force_q <= 1'b0;     trig_q <= 1'b0;
      busy_q <= 1'b0;        rd_ptr_q <= '0;      rd_cnt_q <= '0;
      pend_q <= 1'b0;        pend_last_q <= 1'b0;
      tvalid_q <= 1'b0;      tdata_q <= '0;       tlast_q <= 1'b0;
      pf_vld_q <= 1'b0;      pf_data_q <= '0;     pf_last_q <= 1'b0;
    end else begin
      state_q <= state_d;    mode_q <= mode_d;    level_q <= level_d;
      edge_q <= edge_d;      pretrig_q <= pretrig_d; decim_q <= decim_d;
      dec_cnt_q <= dec_cnt_d; wr_ptr_q <= wr_ptr_d; cnt_q <= cnt_d;
      trig_addr_q <= trig_addr_d; prev_q <= prev_d; prev_vld_q <= prev_vld_d;
      to_cnt_q <= to_cnt_d;  force_q <= force_d;  trig_q <= trig_d;
      busy_q <= busy_d;      rd_ptr_q <= rd_ptr_d; rd_cnt_q <= rd_cnt_d;
      pend_q <= pend_d;      pend_last_q <= pend_last_d;
      tvalid_q <= tvalid_d;  tdata_q <= tdata_d;  tlast_q <= tlast_d;
      pf_vld_q <= pf_vld_d;  pf_data_q <= pf_data_d; pf_last_q <= pf_last_d;
    end
  end

  // Sample buffer with one-cycle registered read
  always_ff @(posedge axis_aclk) begin
    if (write_c) mem[wr_ptr_q] <= adc_data;
    if (issue_c) rd_data_q <= mem[rd_ptr_q];
  end

  assign axis_tvalid      = tvalid_q;
  assign axis_tdata       = tdata_q;
  assign axis_tlast       = tlast_q;
  assign status_busy      = busy_q;
  assign status_triggered = trig_q;
endmodule

// File: tb/tb_adc_trigger_capture.sv
// Bench for adc_trigger_capture (DEPTH=16, AUTO_TIMEOUT=50): expected beats are queued as each
// scenario's stimulus is driven and compared against the stream as it is consumed.
module tb_adc_trigger_capture;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       adc_valid;
  logic [7:0] adc_data;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_level;
  logic       cfg_edge;
  logic [3:0] cfg_pretrig;
  logic [7:0] cfg_decim;
  logic       arm;
  logic       tvalid, tready, tlast, busy, trig;
  logic [7:0] tdata;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  adc_trigger_capture #(.DATA_W(8), .DEPTH(16), .AUTO_TIMEOUT(50)) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n), .adc_valid(adc_valid), .adc_data(adc_data),
    .cfg_mode(cfg_mode), .cfg_level(cfg_level), .cfg_edge(cfg_edge), .cfg_pretrig(cfg_pretrig),
    .cfg_decim(cfg_decim), .arm(arm), .axis_tvalid(tvalid), .axis_tready(tready),
    .axis_tdata(tdata), .axis_tlast(tlast), .status_busy(busy), .status_triggered(trig)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0; adc_valid = 1'b0; adc_data = '0; arm = 1'b0; tready = 1'b1;
    cfg_mode = '0; cfg_level = '0; cfg_edge = 1'b0; cfg_pretrig = '0; cfg_decim = '0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic setup_and_arm(input logic [1:0] mode, input logic [7:0] level, input logic edg,
                               input logic [3:0] pre, input logic [7:0] decim);
    cfg_mode = mode; cfg_level = level; cfg_edge = edg; cfg_pretrig = pre; cfg_decim = decim;
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
  endtask

  task automatic push_ramp(input logic [7:0] start, input logic [7:0] step, input int n);
    logic [7:0] v;
    v = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      v = v + step;
    end
  endtask

  task automatic drive_ramp(input logic [7:0] start, input logic [7:0] step, input int n);
    logic [7:0] v;
    v = start;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      adc_valid = 1'b1;
      adc_data  = v;
      v = v + step;
    end
    @(posedge clk); #1 adc_valid = 1'b0;
  endtask

  // Consume n beats, checking each against the queue and holding data stable while stalled.
  task automatic collect(input int n, input bit rnd, input int budget, input string tag,
                         output int span, output logic trig_first);
    int got, cyc, first_cyc, last_cyc;
    bit stall;
    logic [7:0] hd, e;
    logic hl, exp_last;
    got = 0; cyc = 0; first_cyc = 0; last_cyc = 0; stall = 0; hd = '0; hl = 1'b0;
    trig_first = 1'b0;
    while (got < n && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (stall) begin
        checks++;
        if (tvalid !== 1'b1 || tdata !== hd || tlast !== hl) begin
          errors++;
          $display("FAIL %s stall_hold: tvalid=%b tdata=%h tlast=%b, required 1 %h %b",
                   tag, tvalid, tdata, tlast, hd, hl);
        end
      end
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tvalid === 1'b1 && tready) begin
        if (got == 0) begin
          first_cyc  = cyc;
          trig_first = trig;
        end
        last_cyc = cyc;
        e = 8'hxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        exp_last = ((got % 16) == 15);
        checks++;
        if (tdata !== e) begin
          errors++;
          $display("FAIL %s beat%0d tdata: got %h, required %h", tag, got, tdata, e);
        end
        checks++;
        if (tlast !== exp_last) begin
          errors++;
          $display("FAIL %s beat%0d tlast: got %b, required %b", tag, got, tlast, exp_last);
        end
        got++;
      end
      stall = (tvalid === 1'b1) && !tready;
      hd = tdata;
      hl = tlast;
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s beat_count: got %0d, required %0d", tag, got, n);
    end
    span = last_cyc - first_cyc;
    @(posedge clk); #1 tready = 1'b1;
  endtask

  task automatic test_reset();
    int span;
    do_reset();
    @(posedge clk); #1;
    checks++;
    if ({tvalid, tdata, tlast, busy, trig} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h l=%b busy=%b trig=%b, required all 0",
               tvalid, tdata, tlast, busy, trig);
    end
    span = 0;
  endtask

  task automatic test_rising();
    int span;
    logic tf;
    do_reset();
    setup_and_arm(2'd1, 8'h80, 1'b0, 4'd4, 8'd0);
    push_ramp(8'h40, 8'h10, 16);
    fork
      drive_ramp(8'h00, 8'h10, 20);
      collect(16, 1'b0, 200, "rising", span, tf);
    join
    checks++;
    if (span !== 15) begin
      errors++;
      $display("FAIL rising no_bubble: first-to-last beat span %0d, required 15", span);
    end
    checks++;
    if (busy !== 1'b1 || trig !== 1'b0) begin
      errors++;
      $display("FAIL rising rearm: busy=%b trig=%b, required busy=1 trig=0", busy, trig);
    end
  endtask

  task automatic test_falling();
    int span;
    logic tf;
    do_reset();
    setup_and_arm(2'd1, 8'h80, 1'b1, 4'd4, 8'd0);
    push_ramp(8'hC0, 8'hF0, 16);
    fork
      drive_ramp(8'hF0, 8'hF0, 19);
      collect(16, 1'b0, 200, "falling", span, tf);
    join
    checks++;
    if (tf !== 1'b1) begin
      errors++;
      $display("FAIL falling triggered_before_tvalid: got %b, required 1", tf);
    end
  endtask

  task automatic test_auto();
    int span;
    logic tf;
    do_reset();
    setup_and_arm(2'd0, 8'h80, 1'b0, 4'd4, 8'd0);
    push_ramp(8'h20, 8'h00, 32);
    fork
      drive_ramp(8'h20, 8'h00, 300);
      collect(32, 1'b0, 400, "auto", span, tf);
    join
  endtask

  task automatic test_decim();
    int span;
    logic tf;
    do_reset();
    setup_and_arm(2'd1, 8'h10, 1'b0, 4'd0, 8'd2);
    push_ramp(8'd18, 8'd3, 16);
    fork
      drive_ramp(8'd0, 8'd1, 64);
      collect(16, 1'b0, 300, "decim", span, tf);
    join
  endtask

  task automatic test_backpressure();
    int span, extra;
    logic tf;
    do_reset();
    setup_and_arm(2'd1, 8'h80, 1'b0, 4'd4, 8'd0);
    push_ramp(8'h40, 8'h10, 16);
    fork
      drive_ramp(8'h00, 8'h10, 20);
      collect(16, 1'b1, 400, "stall", span, tf);
    join
    extra = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (tvalid === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall extra_beats: got %0d extra, %0d unsent, required 0 0", extra, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    int span;
    logic tf;
    do_reset();
    setup_and_arm(2'd2, 8'h80, 1'b0, 4'd4, 8'd0);
    push_ramp(8'h40, 8'h10, 7);
    fork
      drive_ramp(8'h00, 8'h10, 20);
      collect(7, 1'b0, 200, "midread", span, tf);
    join
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tvalid, tdata, tlast, busy, trig} !== 12'h000) begin
      errors++;
      $display("FAIL midread reset_outputs: got v=%b d=%h l=%b busy=%b trig=%b, required all 0",
               tvalid, tdata, tlast, busy, trig);
    end
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    setup_and_arm(2'd2, 8'h80, 1'b0, 4'd4, 8'd0);
    push_ramp(8'h40, 8'h10, 16);
    fork
      drive_ramp(8'h00, 8'h10, 20);
      collect(16, 1'b0, 200, "after_reset", span, tf);
    join
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b tvalid=%b, required 0 0", busy, tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_falling();
    test_auto();
    test_decim();
    test_backpressure();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
